// File: rtl/ttc_pkg.sv
// Shared types and sizes for the truth-table checker.
package ttc_pkg;
  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;
  localparam int ERR_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } ttc_state_e;
endpackage

// File: rtl/ttc_settle_timer.sv
// Down-counter that times the settle window; holds at zero instead of wrapping.
module ttc_settle_timer
  import ttc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/truth_table_checker.sv
// Walks a 2-input device through all four vectors and counts mismatches
// against EXP_TT. Define TTC_FAIL_CAPTURE_EN to expose the first failing vector.
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXP_TT     = 4'b1000,
  parameter int                 SETTLE_CYC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef TTC_FAIL_CAPTURE_EN
  ,
  output logic [IDX_W-1:0] fail_vec,
  output logic             fail_vld
`endif
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

  ttc_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [ERR_W-1:0] err_q;
  logic             a_q, b_q, busy_q, done_q;
  logic             tmr_zero;
  logic             mismatch;

  assign mismatch = (y != EXP_TT[idx_q]);

  ttc_settle_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == APPLY),
    .dec_i   (state_q == SETTLE),
    .value_i (LOAD_VAL),
    .zero_o  (tmr_zero)
  );

`ifdef TTC_FAIL_CAPTURE_EN
  logic [IDX_W-1:0] fail_vec_q;
  logic             fail_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec_q <= '0;
      fail_vld_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      fail_vec_q <= '0;
      fail_vld_q <= 1'b0;
    end else if (state_q == SAMPLE && mismatch && !fail_vld_q) begin
      fail_vec_q <= idx_q;
      fail_vld_q <= 1'b1;
    end
  end

  assign fail_vec = fail_vec_q;
  assign fail_vld = fail_vld_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= APPLY;
            idx_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        APPLY: begin
          a_q     <= idx_q[1];
          b_q     <= idx_q[0];
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (tmr_zero) state_q <= SAMPLE;
        end
        SAMPLE: begin
          // Saturate so a miswired device can never wrap the count.
          if (mismatch && (err_q != ERR_W'(NUM_VEC)))
            err_q <= err_q + ERR_W'(1);
          if (idx_q == IDX_W'(NUM_VEC - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = done_q && (err_q == '0);
endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: expected pass results are queued at start and checked at done.
module tb_truth_table_checker;
  localparam int         N1     = 10;
  localparam int         STRIDE = N1 + 2;
  localparam logic [3:0] EXP_TB = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic       a, b, y, busy, done, pass;
  logic [2:0] err_cnt;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [2:0] err2;
`ifdef TTC_FAIL_CAPTURE_EN
  logic [1:0] fail_vec, fail_vec2;
  logic       fail_vld, fail_vld2;
`endif

  int mode = 0;
  int errors = 0, checks = 0;

  function automatic logic dev(int m, logic x, logic z);
    case (m)
      0:       return x & z;
      1:       return 1'b1;
      2:       return x | z;
      default: return ~(x & z);
    endcase
  endfunction

  assign y  = dev(mode, a, b);
  assign y2 = a2 & b2;

  truth_table_checker #(.EXP_TT(4'b1000), .SETTLE_CYC(N1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef TTC_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec), .fail_vld(fail_vld)
`endif
  );

  truth_table_checker #(.EXP_TT(4'b1000), .SETTLE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef TTC_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec2), .fail_vld(fail_vld2)
`endif
  );

  typedef struct {
    logic [2:0] err;
    logic       pss;
    logic [1:0] fv;
    logic       fvld;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_a"}, a, 0);
    check({tag, "_b"}, b, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
`ifdef TTC_FAIL_CAPTURE_EN
    check({tag, "_fvld"}, fail_vld, 0);
    check({tag, "_fvec"}, fail_vec, 0);
`endif
  endtask

  // Model the pass independently from the device function and the expected table.
  task automatic kick(int m);
    exp_t e;
    e.err = '0; e.fv = '0; e.fvld = 1'b0;
    mode = m;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      if (dev(m, v[1], v[0]) !== EXP_TB[i]) begin
        if (!e.fvld) begin e.fvld = 1'b1; e.fv = v; end
        e.err = e.err + 3'd1;
      end
    end
    e.pss = (e.err == 3'd0);
    exp_q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_pass(string tag, int repulse);
    int   c;
    exp_t e;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      start = (c == repulse);
      if (c == 6) check({tag, "_busy"}, busy, 1);
      for (int k = 0; k < 4; k++)
        if (c == k * STRIDE + 6) check($sformatf("%s_ab%0d", tag, k), {a, b}, k);
    end while (!done && c < 200);
    start = 1'b0;
    check({tag, "_latency"}, c, 4 * STRIDE);
    e = exp_q.pop_front();
    check({tag, "_err"}, err_cnt, e.err);
    check({tag, "_pass"}, pass, e.pss);
    check({tag, "_busy_done"}, busy, 0);
`ifdef TTC_FAIL_CAPTURE_EN
    check({tag, "_fvld"}, fail_vld, e.fvld);
    check({tag, "_fvec"}, fail_vec, e.fv);
`endif
  endtask

  initial begin
    int c, hi, lo;
    exp_t dropped;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    start2 = 1'b1;

    kick(0); finish_pass("and", 0);
    kick(1); finish_pass("tied1", 0);
    kick(2); finish_pass("or", 0);
    kick(0); finish_pass("repulse", 16);
    kick(3); finish_pass("nand", 0);

    // Reset in the middle of vector 2's settle window.
    kick(0);
    repeat (28) @(negedge clk);
    check("midrst_pre_ab", {a, b}, 2);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_vals("midrst");
    dropped = exp_q.pop_front();
    repeat (3) @(negedge clk);
    check("midrst_stay_idle", busy, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_dom_busy", busy, 0);
    @(negedge clk);
    check("rst_dom_busy2", busy, 0);

    kick(0); finish_pass("after_rst", 0);

    // Short settle, start held: done is a one-cycle pulse every pass.
    c = 0;
    while (!done2 && c < 100) begin @(negedge clk); c++; end
    check("b2b_first_done", done2, 1);
    check("b2b_pass", pass2, 1);
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      while (done2 && hi < 50) begin @(negedge clk); hi++; end
      lo = 0;
      while (!done2 && lo < 50) begin @(negedge clk); lo++; end
      check($sformatf("b2b_hi%0d", p), hi, 1);
      check($sformatf("b2b_lo%0d", p), lo, 12);
      check($sformatf("b2b_err%0d", p), err2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
